// File: rtl/iomem_bus_ctrl_pkg.sv
// iomem_bus_ctrl_pkg
//   Shared definitions for the iomem bus controller: FSM state encoding,
//   peripheral page map, default error read data and the page decode helper.
//   No ports (package).
package iomem_bus_ctrl_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    // Address bits [31:24] of each peripheral.
    localparam logic [7:0] PAGE_GPIO   = 8'h03;
    localparam logic [7:0] PAGE_AUDIO  = 8'h04;
    localparam logic [7:0] PAGE_VIDEO  = 8'h05;
    localparam logic [7:0] PAGE_SDCARD = 8'h06;
    localparam logic [7:0] PAGE_I2C    = 8'h07;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Slave index relative to the base page; pages below the base wrap to large values
    // so they decode as unmapped.
    function automatic logic [7:0] page_sel(logic [7:0] page, logic [7:0] base);
        return page - base;
    endfunction

endpackage

// File: rtl/iomem_bus_ctrl_if.sv
// iomem_bus_ctrl_if
//   Groups the CPU-side iomem handshake and the shared peripheral bus.
//   Signals:
//     cpu_valid/cpu_ready/cpu_wstrb/cpu_addr/cpu_wdata/cpu_rdata : SoC iomem port
//     slv_valid/slv_ready                                        : per-slave handshake
//     slv_rdata                                                  : flattened slave read data
//     slv_addr/slv_wdata/slv_wstrb                               : latched shared request
//   Modports:
//     master : the bus controller (answers the CPU, drives the peripherals)
//     slave  : the environment (CPU plus peripherals)
interface iomem_bus_ctrl_if
    import iomem_bus_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 5
);
    logic                         cpu_valid;
    logic                         cpu_ready;
    logic [3:0]                   cpu_wstrb;
    logic [DATA_W-1:0]            cpu_addr;
    logic [DATA_W-1:0]            cpu_wdata;
    logic [DATA_W-1:0]            cpu_rdata;

    logic [NUM_SLAVES-1:0]        slv_valid;
    logic [NUM_SLAVES-1:0]        slv_ready;
    logic [DATA_W*NUM_SLAVES-1:0] slv_rdata;
    logic [DATA_W-1:0]            slv_addr;
    logic [DATA_W-1:0]            slv_wdata;
    logic [3:0]                   slv_wstrb;

    modport master (
        input  cpu_valid, cpu_wstrb, cpu_addr, cpu_wdata, slv_ready, slv_rdata,
        output cpu_ready, cpu_rdata, slv_valid, slv_addr, slv_wdata, slv_wstrb
    );

    modport slave (
        output cpu_valid, cpu_wstrb, cpu_addr, cpu_wdata, slv_ready, slv_rdata,
        input  cpu_ready, cpu_rdata, slv_valid, slv_addr, slv_wdata, slv_wstrb
    );

endinterface

// File: rtl/iomem_timeout_ctr.sv
// iomem_timeout_ctr
//   Per-access watchdog counter.
//   Ports:
//     clk     : system clock
//     reset   : synchronous active-high reset
//     clr     : load zero (has priority over en)
//     en      : increment by one
//     expired : count has reached TIMEOUT-1
module iomem_timeout_ctr #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TIMEOUT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/iomem_bus_ctrl.sv
// iomem_bus_ctrl
//   Registered, one-transaction-at-a-time iomem controller. Decodes the CPU
//   address page to one of NUM_SLAVES peripherals, holds the request until the
//   selected slave completes or the watchdog expires, then returns a one-cycle
//   cpu_ready pulse. Timeouts return ERR_DATA, set a sticky flag and record the
//   faulting address.
//   Ports:
//     clk      : system clock
//     reset    : synchronous active-high reset
//     bus      : iomem_bus_ctrl_if master modport (CPU side + peripheral bus)
//     err_clr  : clears err_flag (a simultaneous timeout wins)
//     err_flag : sticky timeout indicator
//     err_addr : address of the most recent timed-out access
module iomem_bus_ctrl
    import iomem_bus_ctrl_pkg::*;
#(
    parameter int unsigned       NUM_SLAVES = 5,
    parameter logic [7:0]        BASE_PAGE  = PAGE_GPIO,
    parameter int unsigned       TIMEOUT    = 255,
    parameter int unsigned       TIMEOUT_W  = 8,
    parameter logic [DATA_W-1:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    iomem_bus_ctrl_if.master  bus,
    input  logic              err_clr,
    output logic              err_flag,
    output logic [DATA_W-1:0] err_addr
);

    state_e            state_q, state_d;
    logic [7:0]        sel_q, sel_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_flag_q, err_flag_d;
    logic [DATA_W-1:0] err_addr_q, err_addr_d;

    logic              ctr_clr;
    logic              ctr_en;
    logic              ctr_expired;

    logic [7:0]        dec_sel;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;

    iomem_timeout_ctr #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset   (reset),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (ctr_expired)
    );

    assign dec_sel = page_sel(bus.cpu_addr[31:24], BASE_PAGE);

    // Pick the latched slave's handshake; other slaves' ready lines are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == 8'(i)) begin
                sel_ready = bus.slv_ready[i];
                sel_rdata = bus.slv_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        err_flag_d = err_flag_q & ~err_clr;
        err_addr_d = err_addr_q;
        ctr_clr    = 1'b0;
        ctr_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // cpu_ready is only high in StResp, so a valid still held during the
                // response cycle cannot be accepted twice.
                if (bus.cpu_valid && !bus.cpu_ready) begin
                    sel_d   = dec_sel;
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    wstrb_d = bus.cpu_wstrb;
                    if (32'(dec_sel) < NUM_SLAVES) begin
                        state_d = StAccess;
                        ctr_clr = 1'b1;
                    end else begin
                        // Unmapped page: answer immediately, writes are dropped.
                        state_d = StResp;
                        rdata_d = '0;
                    end
                end
            end
            StAccess: begin
                ctr_en = 1'b1;
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    state_d = StResp;
                end else if (ctr_expired) begin
                    rdata_d    = ERR_DATA;
                    err_flag_d = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Outputs.
    always_comb begin
        bus.slv_valid = '0;
        if (state_q == StAccess) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                bus.slv_valid[i] = (sel_q == 8'(i));
            end
        end
    end

    assign bus.cpu_ready = (state_q == StResp);
    assign bus.cpu_rdata = rdata_q;
    assign bus.slv_addr  = addr_q;
    assign bus.slv_wdata = wdata_q;
    assign bus.slv_wstrb = wstrb_q;
    assign err_flag      = err_flag_q;
    assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_iomem_bus_ctrl.sv
// tb_iomem_bus_ctrl
//   Directed bench for iomem_bus_ctrl. A transaction-level model predicts every
//   output per cycle; a negedge process compares the DUT against it. A few
//   literal checks pin the model to hand-computed values.
module tb_iomem_bus_ctrl;

    localparam int unsigned NS      = 5;
    localparam int unsigned TMO     = 16;
    localparam logic [7:0]  BASE    = 8'h03;
    localparam logic [31:0] ERRD    = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic reset;
    logic err_clr;
    logic err_flag;
    logic [31:0] err_addr;

    iomem_bus_ctrl_if #(.NUM_SLAVES(NS)) bus ();

    iomem_bus_ctrl #(
        .NUM_SLAVES (NS),
        .BASE_PAGE  (BASE),
        .TIMEOUT    (TMO),
        .TIMEOUT_W  (8),
        .ERR_DATA   (ERRD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .err_clr  (err_clr),
        .err_flag (err_flag),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model of the outputs for the current cycle.
    logic [NS-1:0] m_valid;
    logic          m_ready;
    logic [31:0]   m_rdata;
    logic          m_err_flag;
    logic [31:0]   m_err_addr;
    logic [31:0]   m_slv_addr;
    logic [31:0]   m_slv_wdata;
    logic [3:0]    m_slv_wstrb;
    logic          chk_en = 1'b0;

    // Observations used by the literal checks.
    int          vcnt;
    logic [NS-1:0] last_valid;
    logic [31:0] last_resp_rdata;
    int          ready_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_ready", 32'(bus.cpu_ready), 32'(m_ready));
            chk("cpu_rdata", bus.cpu_rdata, m_rdata);
            chk("slv_valid", 32'(bus.slv_valid), 32'(m_valid));
            chk("slv_addr", bus.slv_addr, m_slv_addr);
            chk("slv_wdata", bus.slv_wdata, m_slv_wdata);
            chk("slv_wstrb", 32'(bus.slv_wstrb), 32'(m_slv_wstrb));
            chk("err_flag", 32'(err_flag), 32'(m_err_flag));
            chk("err_addr", err_addr, m_err_addr);
            if (bus.slv_valid != '0) begin
                vcnt++;
                last_valid = bus.slv_valid;
            end
            if (bus.cpu_ready) begin
                ready_cnt++;
                last_resp_rdata = bus.cpu_rdata;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_valid     = '0;
        m_ready     = 1'b0;
        m_rdata     = '0;
        m_err_flag  = 1'b0;
        m_err_addr  = '0;
        m_slv_addr  = '0;
        m_slv_wdata = '0;
        m_slv_wstrb = '0;
    endtask

    // One complete transaction. rdy_k < 0 means the slave never answers.
    // clr_last raises err_clr in the final access cycle.
    task automatic txn(input logic [31:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, input int rdy_k,
                       input logic [31:0] srd, input bit clr_last);
        logic [7:0] sel8;
        bit         mapped;
        bit         done;
        bit         tmo;
        sel8   = addr[31:24] - BASE;
        mapped = (32'(sel8) < NS);
        vcnt      = 0;
        ready_cnt = 0;
        for (int i = 0; i < NS; i++) begin
            bus.slv_rdata[32*i +: 32] = 32'h1111_1111 * (i + 1);
        end
        if (mapped) bus.slv_rdata[32*sel8 +: 32] = srd;
        // Ready while idle must be ignored.
        bus.slv_ready = '1;
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = addr;
        bus.cpu_wstrb = wstrb;
        bus.cpu_wdata = wdata;
        step();
        bus.slv_ready = '0;
        m_slv_addr  = addr;
        m_slv_wdata = wdata;
        m_slv_wstrb = wstrb;
        if (mapped) begin
            for (int k = 0; k < TMO; k++) begin
                m_valid = NS'(1) << sel8;
                m_ready = 1'b0;
                done = (k == rdy_k);
                tmo  = !done && (k == TMO - 1);
                // Other slaves answering must not complete the access.
                bus.slv_ready = done ? (NS'(1) << sel8) : ~(NS'(1) << sel8);
                err_clr = tmo && clr_last;
                step();
                bus.slv_ready = '0;
                err_clr = 1'b0;
                if (done) begin
                    m_rdata = srd;
                    break;
                end
                if (tmo) begin
                    m_rdata    = ERRD;
                    m_err_flag = 1'b1;
                    m_err_addr = addr;
                    break;
                end
            end
        end else begin
            m_rdata = '0;
        end
        // Response cycle: valid lingers and slaves shout ready, both ignored.
        m_valid = '0;
        m_ready = 1'b1;
        bus.slv_ready = '1;
        step();
        bus.slv_ready = '0;
        bus.cpu_valid = 1'b0;
        m_ready = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        err_clr       = 1'b0;
        bus.cpu_valid = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wstrb = '0;
        bus.cpu_wdata = '0;
        bus.slv_ready = '0;
        bus.slv_rdata = '0;
        model_reset();
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Read slave 2, ready in access cycle 3.
        txn(32'h0500_0010, 4'h0, 32'h0, 3, 32'h1234_5678, 1'b0);
        chk("t1_valid_cycles", 32'(vcnt), 32'd4);
        chk("t1_valid_onehot", 32'(last_valid), 32'b00100);
        chk("t1_resp_rdata", last_resp_rdata, 32'h1234_5678);
        chk("t1_ready_pulses", 32'(ready_cnt), 32'd1);

        // Write slave 0, immediate ready.
        txn(32'h0300_0000, 4'hF, 32'hA5A5_A5A5, 0, 32'h0BAD_F00D, 1'b0);
        chk("t2_valid_cycles", 32'(vcnt), 32'd1);
        chk("t2_err_flag", 32'(err_flag), 32'd0);

        // Unmapped reads above and below the window, unmapped write at the first page past it.
        txn(32'h0900_0000, 4'h0, 32'h0, 0, 32'h0, 1'b0);
        chk("t3_valid_cycles", 32'(vcnt), 32'd0);
        chk("t3_resp_rdata", last_resp_rdata, 32'h0);
        txn(32'h0200_0040, 4'h0, 32'h0, 0, 32'h0, 1'b0);
        txn(32'h0800_0000, 4'h3, 32'h5555_0000, 0, 32'h0, 1'b0);
        chk("t3b_valid_cycles", 32'(vcnt), 32'd0);

        // Slave 4 never ready, err_clr coincides with the timeout.
        txn(32'h0700_0000, 4'h0, 32'h0, -1, 32'h0, 1'b1);
        chk("t4_valid_cycles", 32'(vcnt), 32'd16);
        chk("t4_resp_rdata", last_resp_rdata, 32'hDEAD_BEEF);
        chk("t4_err_flag", 32'(err_flag), 32'd1);
        chk("t4_err_addr", err_addr, 32'h0700_0000);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_err_flag = 1'b0;
        step();

        // Ready on the very cycle the watchdog would expire: no error.
        txn(32'h0600_0008, 4'h0, 32'h0, TMO - 1, 32'hCAFE_0001, 1'b0);
        chk("t5_valid_cycles", 32'(vcnt), 32'd16);
        chk("t5_resp_rdata", last_resp_rdata, 32'hCAFE_0001);
        chk("t5_err_flag", 32'(err_flag), 32'd0);

        // Reset during access cycle 2 of a slave-1 read.
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 32'h0400_0004;
        bus.cpu_wstrb = 4'h0;
        bus.cpu_wdata = 32'h0;
        step();
        m_slv_addr  = 32'h0400_0004;
        m_slv_wdata = 32'h0;
        m_slv_wstrb = 4'h0;
        for (int k = 0; k < 3; k++) begin
            m_valid = NS'(2);
            if (k == 2) reset = 1'b1;
            step();
        end
        reset         = 1'b0;
        bus.cpu_valid = 1'b0;
        model_reset();
        ready_cnt = 0;
        step();
        step();
        chk("t6_no_ready", 32'(ready_cnt), 32'd0);
        chk("t6_err_addr", err_addr, 32'h0);

        // Normal access after reset.
        txn(32'h0600_0020, 4'h0, 32'h0, 1, 32'h7777_8888, 1'b0);
        chk("t7_valid_cycles", 32'(vcnt), 32'd2);
        chk("t7_resp_rdata", last_resp_rdata, 32'h7777_8888);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iomem_bus_ctrl.md
Name: iomem_bus_ctrl

Overview:
- Sequences every PicoRV32 iomem transaction to one of up to NUM_SLAVES peripherals (GPIO, audio, video, SD card, I2C) mapped by address page.
- Replaces the combinational ready/rdata priority mux with a registered, one-transaction-at-a-time controller.
- Adds a per-access timeout watchdog, a sticky error flag and a captured fault address, so a hung or absent peripheral cannot stall the CPU.

Parameters:
- NUM_SLAVES, 5: number of slave ports. Slave i maps to page BASE_PAGE+i.
- BASE_PAGE, 8'h03: address bits [31:24] of slave 0.
- TIMEOUT, 255: maximum ACCESS cycles before the access is aborted. Range 1 to 2^TIMEOUT_W-1.
- TIMEOUT_W, 8: width of the timeout counter.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on a timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_valid  in  1  iomem request from the SoC
- cpu_ready  out  1  one-cycle completion pulse to the SoC
- cpu_wstrb  in  4  byte strobes; 0 = read
- cpu_addr  in  32  request address
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid while cpu_ready=1
- slv_valid  out  NUM_SLAVES  one-hot request to the selected slave
- slv_ready  in  NUM_SLAVES  per-slave completion
- slv_rdata  in  32*NUM_SLAVES  flattened read data; slave i occupies bits [32i+31:32i]
- slv_addr  out  32  latched address, shared by all slaves
- slv_wdata  out  32  latched write data, shared
- slv_wstrb  out  4  latched strobes, shared
- err_clr  in  1  clears err_flag
- err_flag  out  1  sticky timeout indicator
- err_addr  out  32  address of the most recent timed-out access

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset mid-transaction: abort, return to IDLE, no cpu_ready pulse.
- States: IDLE, ACCESS, RESP.
- IDLE, on cpu_valid=1 with cpu_ready=0:
  - Latch addr, wdata and wstrb into the slv_* registers.
  - Decode sel = cpu_addr[31:24] - BASE_PAGE.
  - If sel < NUM_SLAVES: go to ACCESS, counter = 0.
  - Otherwise (unmapped): go to RESP with rdata = 0 and no error. An unmapped write is dropped.
- ACCESS:
  - slv_valid[sel]=1; every other slv_valid bit is 0. Counter increments each cycle.
  - slv_ready[sel]=1: capture slv_rdata[sel] into cpu_rdata, go to RESP.
  - Else if counter == TIMEOUT-1: cpu_rdata = ERR_DATA, err_flag = 1, err_addr = slv_addr, go to RESP.
  - slv_ready and timeout in the same cycle: ready wins, no error.
  - slv_ready on unselected slaves, or outside ACCESS, is ignored.
- RESP:
  - cpu_ready=1 for exactly one cycle, all slv_valid=0, then go to IDLE.
  - cpu_rdata is held until the next capture.
- Latency: a request accepted at edge 0 asserts slv_valid after edge 0. Slave ready in ACCESS cycle k (k=0 first) gives cpu_ready in the cycle after, i.e. k+2 cycles after the accept edge. Unmapped access: cpu_ready 1 cycle after accept.
- cpu_valid is not re-sampled until the controller returns to IDLE. Deasserting it mid-transaction is illegal; the transaction still completes.
- The IDLE accept condition excludes the RESP cycle, so a lingering valid is never double-accepted.
- err_clr: clears err_flag. If a new timeout occurs in the same cycle, set wins. err_addr is overwritten by every timeout and never cleared except by reset.
- Writes: the slave's completion is forwarded the same way as reads. cpu_rdata is still captured from the slave's rdata and is don't-care to the CPU.

Decomposition:
- Shared package holds:
  - state encoding enum (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - page constants (GPIO 8'h03, AUDIO 8'h04, VIDEO 8'h05, SDCARD 8'h06, I2C 8'h07);
  - default ERR_DATA.
- One natural sub-module: iomem_timeout_ctr, a TIMEOUT_W-bit counter with clear/enable and an expiry flag at TIMEOUT-1.
- Decode, FSM and rdata capture stay in the top block.

Test Plan:
- Read at 0x0500_0010, slave 2 raises ready with rdata 0x1234_5678 in ACCESS cycle 3 -> slv_valid=5'b00100 for 4 cycles, then cpu_ready one cycle with cpu_rdata=0x1234_5678.
- Write at 0x0300_0000 with wstrb=4'hF, wdata=0xA5A5_A5A5, slave 0 ready immediately -> slv_wdata=0xA5A5_A5A5, cpu_ready 2 cycles after accept, err_flag=0.
- Read at 0x0900_0000 (unmapped) -> no slv_valid, cpu_ready 1 cycle after accept, cpu_rdata=0.
- Slave 4 never ready, TIMEOUT=16 -> slv_valid[4] high for 16 cycles, then cpu_ready with cpu_rdata=0xDEAD_BEEF, err_flag=1, err_addr=0x0700_0000.
- Timeout and err_clr in the same cycle -> err_flag stays 1. err_clr alone the next cycle -> err_flag=0.
- reset asserted during ACCESS cycle 2 -> next cycle: all outputs 0, no cpu_ready. A new request then completes normally.
